// File: rtl/acondicionador_iv_entrada.sv
// ADC I/V pair averager with IEEE-754 single conversion and valid/ready output.
// Optional macro ROUND_AVG_EN selects round-half-up averaging instead of truncation.
module acondicionador_iv_entrada #(
  parameter int ADC_W  = 12,
  parameter int LOG2_N = 3
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_i,
  input  logic [ADC_W-1:0] adc_v,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [31:0]      I,
  output logic [31:0]      V,
  output logic             overrun
);

  // state | meaning
  // ACC   | accumulating sample pairs
  // CONV  | one cycle: average and convert to float
  // HOLD  | presenting I/V, waiting for out_ready
  typedef enum logic [1:0] {ACC, CONV, HOLD} state_t;

  localparam int AW   = ADC_W + LOG2_N;
  localparam int CW   = LOG2_N + 1;
  localparam int N    = 1 << LOG2_N;
  localparam int HALF = N / 2;

  state_t          state, state_nx;
  logic [AW-1:0]   acc_i, acc_v;
  logic [CW-1:0]   cnt;
  logic            acc_en, clr, load_out, drop, valid_nx;
  logic [ADC_W-1:0] avg_i, avg_v;
  logic [AW-1:0]   rnd_i, rnd_v;

  function automatic logic [31:0] to_float(input logic [ADC_W-1:0] a);
    logic [31:0] f;
    logic [23:0] x;
    logic [4:0]  p;
    f = '0;
    x = 24'(a);
    p = '0;
    for (int k = 0; k < ADC_W; k++)
      if (a[k]) p = 5'(k);
    if (a != '0) begin
      x = x << (5'd23 - p);
      f = {1'b0, 8'd127 + {3'b000, p}, x[22:0]};
    end
    return f;
  endfunction

`ifdef ROUND_AVG_EN
  // Rounded sum cannot exceed AW bits: N*(2^ADC_W-1) + N/2 < N*2^ADC_W.
  assign rnd_i = acc_i + AW'(HALF);
  assign rnd_v = acc_v + AW'(HALF);
`else
  assign rnd_i = acc_i;
  assign rnd_v = acc_v;
`endif
  assign avg_i = ADC_W'(rnd_i >> LOG2_N);
  assign avg_v = ADC_W'(rnd_v >> LOG2_N);

  always_comb begin
    state_nx = state;
    acc_en   = 1'b0;
    clr      = 1'b0;
    load_out = 1'b0;
    drop     = 1'b0;
    valid_nx = out_valid;
    case (state)
      ACC: begin
        if (adc_valid) begin
          acc_en = 1'b1;
          if (cnt == CW'(N - 1)) state_nx = CONV;
        end
      end
      CONV: begin
        load_out = 1'b1;
        clr      = 1'b1;
        valid_nx = 1'b1;
        state_nx = HOLD;
        drop     = adc_valid;
      end
      HOLD: begin
        if (out_ready) begin
          valid_nx = 1'b0;
          state_nx = ACC;
          // A pair arriving with the handshake starts the next block.
          if (adc_valid) begin
            acc_en = 1'b1;
            if (cnt == CW'(N - 1)) state_nx = CONV;
          end
        end else begin
          drop = adc_valid;
        end
      end
      default: state_nx = ACC;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= ACC;
      acc_i     <= '0;
      acc_v     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      I         <= '0;
      V         <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= valid_nx;
      overrun   <= drop;
      if (clr) begin
        acc_i <= '0;
        acc_v <= '0;
        cnt   <= '0;
      end else if (acc_en) begin
        acc_i <= acc_i + AW'(adc_i);
        acc_v <= acc_v + AW'(adc_v);
        cnt   <= cnt + 1'b1;
      end
      if (load_out) begin
        I <= to_float(avg_i);
        V <= to_float(avg_v);
      end
    end
  end

endmodule

// File: tb/tb_acondicionador_iv_entrada.sv
// Directed bench for acondicionador_iv_entrada: integer-level reference model
// compared every cycle, plus hand-computed float constants for each scenario.
module tb_acondicionador_iv_entrada;
  localparam int ADC_W  = 12;
  localparam int LOG2_N = 3;
  localparam int N      = 1 << LOG2_N;

  logic             CLK = 1'b0;
  logic             reset;
  logic             adc_valid = 1'b0;
  logic [ADC_W-1:0] adc_i = '0;
  logic [ADC_W-1:0] adc_v = '0;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [31:0]      I, V;
  logic             overrun;

  int n_checks = 0;
  int n_fail   = 0;

  acondicionador_iv_entrada #(.ADC_W(ADC_W), .LOG2_N(LOG2_N)) dut (
    .CLK(CLK), .reset(reset), .adc_valid(adc_valid), .adc_i(adc_i), .adc_v(adc_v),
    .out_ready(out_ready), .out_valid(out_valid), .I(I), .V(V), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference float encoding from arithmetic on the integer value.
  function automatic logic [31:0] flt(input longint a);
    int p;
    longint mant;
    if (a == 0) return 32'h0;
    p = 0;
    while ((64'sd1 << (p + 1)) <= a) p++;
    mant = (a - (64'sd1 << p)) * (64'sd1 << (23 - p));
    return {1'b0, 8'(127 + p), 23'(mant)};
  endfunction

  function automatic longint average(input longint sum);
`ifdef ROUND_AVG_EN
    return (sum + N / 2) / N;
`else
    return sum / N;
`endif
  endfunction

  // Transaction-level model: counts pairs, remembers a finished block, tracks output ownership.
  int          pairs = 0;
  longint      sum_i = 0, sum_v = 0;
  bit          block_done = 0;
  bit          m_valid = 0, m_ovr = 0;
  logic [31:0] m_i = 0, m_v = 0;

  always @(posedge CLK or posedge reset) begin
    bit take, ovr;
    if (reset) begin
      pairs = 0; sum_i = 0; sum_v = 0; block_done = 0;
      m_valid = 0; m_ovr = 0; m_i = 0; m_v = 0;
    end else begin
      take = 0; ovr = 0;
      if (block_done) begin
        m_i = flt(average(sum_i));
        m_v = flt(average(sum_v));
        m_valid = 1; block_done = 0;
        pairs = 0; sum_i = 0; sum_v = 0;
        ovr = adc_valid;
      end else if (m_valid) begin
        if (out_ready) begin
          m_valid = 0;
          take = adc_valid;
        end else begin
          ovr = adc_valid;
        end
      end else begin
        take = adc_valid;
      end
      if (take) begin
        sum_i += adc_i; sum_v += adc_v; pairs++;
        if (pairs == N) block_done = 1;
      end
      m_ovr = ovr;
    end
  end

  always @(negedge CLK) begin
    if (reset === 1'b0) begin
      check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      check("cyc_overrun", 32'(overrun), 32'(m_ovr));
      check("cyc_I", I, m_i);
      check("cyc_V", V, m_v);
    end
  end

  // Called at a negedge; presents one pair for the next rising edge.
  task automatic pair(input int vi, input int vv);
    adc_valid = 1'b1; adc_i = ADC_W'(vi); adc_v = ADC_W'(vv);
    @(negedge CLK);
    adc_valid = 1'b0;
  endtask

  task automatic burst(input int cnt, input int vi, input int vv);
    for (int k = 0; k < cnt; k++) pair(vi, vv);
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 20; k++) begin
      if (out_valid === 1'b1) break;
      @(negedge CLK);
    end
    check({name, "_valid_seen"}, 32'(out_valid), 32'd1);
  endtask

  task automatic expect_out(input string name, input logic [31:0] ei, input logic [31:0] ev);
    wait_valid(name);
    check({name, "_I"}, I, ei);
    check({name, "_V"}, V, ev);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    @(negedge CLK); @(negedge CLK);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_I", I, 32'h0);
    check("reset_V", V, 32'h0);
    check("reset_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    @(negedge CLK);

    // 1: latency and one-cycle valid with out_ready held high
    burst(N, 2048, 100);
    check("t1_not_yet", 32'(out_valid), 32'd0);
    @(negedge CLK);
    check("t1_valid_2nd_edge", 32'(out_valid), 32'd1);
    check("t1_I", I, 32'h45000000);
    check("t1_V", V, 32'h42C80000);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    check("t1_valid_once", 32'(seen), 32'd0);

    // 2: full-scale / minimum and zero
    burst(N, 4095, 1);
    expect_out("t2a", 32'h457FF000, 32'h3F800000);
    @(negedge CLK);
    burst(N, 0, 0);
    expect_out("t2b", 32'h0, 32'h0);
    @(negedge CLK);

    // 3: sum 84 over 8 pairs -> 10.5 truncated or rounded
    burst(4, 10, 10);
    burst(4, 11, 11);
`ifdef ROUND_AVG_EN
    expect_out("t3", 32'h41300000, 32'h41300000);
`else
    expect_out("t3", 32'h41200000, 32'h41200000);
`endif
    @(negedge CLK);

    // 4: backpressure, drops, then handshake coinciding with a new pair
    out_ready = 1'b0;
    burst(N, 100, 100);
    expect_out("t4a", 32'h42C80000, 32'h42C80000);
    for (int k = 0; k < 3; k++) begin
      pair(2048, 2048);
      check("t4_overrun_pulse", 32'(overrun), 32'd1);
    end
    check("t4_still_valid", 32'(out_valid), 32'd1);
    check("t4_I_held", I, 32'h42C80000);
    out_ready = 1'b1;
    pair(2048, 2048);
    check("t4_handshake_valid", 32'(out_valid), 32'd0);
    check("t4_handshake_ovr", 32'(overrun), 32'd0);
    burst(N - 1, 2048, 2048);
    expect_out("t4b", 32'h45000000, 32'h45000000);
    @(negedge CLK);

    // 5: asynchronous reset mid-block
    burst(5, 4095, 4095);
    #2 reset = 1'b1;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_I", I, 32'h0);
    check("t5_async_V", V, 32'h0);
    check("t5_async_ovr", 32'(overrun), 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    burst(N - 1, 1, 1);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    check("t5_seven_no_valid", 32'(seen), 32'd0);
    pair(1, 1);
    expect_out("t5", 32'h3F800000, 32'h3F800000);
    @(negedge CLK);

    // 6: gaps between pairs
    for (int k = 0; k < N; k++) begin
      pair(100, 100);
      @(negedge CLK);
    end
    expect_out("t6", 32'h42C80000, 32'h42C80000);
    @(negedge CLK); @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
